// File: rtl/prm_status_writer.sv
// prm_status_writer: captures datapath status values into per-slot shadows and writes
// them round-robin into the parameter RAM. Optional macro: PRM_STATUS_WRITER_FILTER_EN.
module prm_status_writer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int N_SLOTS = 4,
  parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_ADDR = {8'd6, 8'd5, 8'd4, 8'd3}
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_SLOTS*DATA_W-1:0] stat_dat,
  input  logic [N_SLOTS-1:0]        stat_val,
  output logic                      wr_req,
  input  logic                      wr_gnt,
  output logic [ADDR_W-1:0]         prm_addr,
  output logic [DATA_W-1:0]         prm_ram_d,
  output logic                      prm_ram_w,
  output logic                      busy,
  output logic [7:0]                ovr_cnt
);

  localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

  state_t            state;
  logic [DATA_W-1:0] shd [N_SLOTS];
  logic [N_SLOTS-1:0] pend;
  logic [N_SLOTS-1:0] pend_nxt;
  logic [N_SLOTS-1:0] cap;
  logic [N_SLOTS-1:0] drop;
  logic [N_SLOTS-1:0] clr;
  logic [N_SLOTS-1:0] ovr;
  logic [SEL_W-1:0]  last;
  logic [SEL_W-1:0]  sel;
  logic              any_pend;
  logic              take;
  logic [3:0]        ovr_n;
  logic [8:0]        ovr_sum;

  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_SLOTS) s = s - N_SLOTS;
    return SEL_W'(s);
  endfunction

  // Round-robin pick starting after the last served slot; the nearest pending slot wins.
  always_comb begin
    any_pend = |pend;
    sel      = last;
    for (int k = N_SLOTS; k >= 1; k--) begin
      if (pend[rr_idx(last, k)]) sel = rr_idx(last, k);
    end
    take     = (state == IDLE) && any_pend;
    clr      = take ? (N_SLOTS'(1) << sel) : '0;
    cap      = stat_val & ~drop;
    ovr      = cap & pend & ~clr;
    pend_nxt = (pend & ~clr) | cap;
    ovr_n    = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      ovr_n = ovr_n + 4'(ovr[i]);
    end
    ovr_sum  = {1'b0, ovr_cnt} + {5'b0, ovr_n};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      last      <= SEL_W'(N_SLOTS - 1);
      pend      <= '0;
      for (int i = 0; i < N_SLOTS; i++) shd[i] <= '0;
      wr_req    <= 1'b0;
      prm_ram_w <= 1'b0;
      prm_addr  <= '0;
      prm_ram_d <= '0;
      busy      <= 1'b0;
      ovr_cnt   <= '0;
    end else begin
      pend <= pend_nxt;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (cap[i]) shd[i] <= stat_dat[i*DATA_W +: DATA_W];
      end
      ovr_cnt <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
      busy    <= take || (state == REQ) || (|pend_nxt);
      case (state)
        IDLE: begin
          // shd[sel] is the pre-edge value, so a same-edge capture is written next time
          if (take) begin
            prm_ram_d <= shd[sel];
            prm_addr  <= SLOT_ADDR[int'(sel)*ADDR_W +: ADDR_W];
            last      <= sel;
            wr_req    <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (wr_gnt) begin
            wr_req    <= 1'b0;
            prm_ram_w <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          prm_ram_w <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          wr_req    <= 1'b0;
          prm_ram_w <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef PRM_STATUS_WRITER_FILTER_EN
  logic [DATA_W-1:0] lastw [N_SLOTS];
  logic [N_SLOTS-1:0] lv;
  logic [SEL_W-1:0]  fly_sel;

  // A strobe repeating the last written value, with nothing newer queued, is dropped.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      drop[i] = lv[i] && !pend[i] && (stat_dat[i*DATA_W +: DATA_W] == lastw[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_SLOTS; i++) lastw[i] <= '0;
      lv      <= '0;
      fly_sel <= '0;
    end else begin
      if (take) fly_sel <= sel;
      if (state == WRITE) begin
        lastw[fly_sel] <= prm_ram_d;
        lv[fly_sel]    <= 1'b1;
      end
    end
  end
`else
  assign drop = '0;
`endif

endmodule

// File: tb/tb_prm_status_writer.sv
// Randomized and directed bench for prm_status_writer against a cycle-level reference model.
module tb_prm_status_writer;

  localparam int N_SLOTS = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
`ifdef PRM_STATUS_WRITER_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic [N_SLOTS*DATA_W-1:0] stat_dat = '0;
  logic [N_SLOTS-1:0]        stat_val = '0;
  logic                      wr_gnt = 1'b0;
  logic                      wr_req;
  logic [ADDR_W-1:0]         prm_addr;
  logic [DATA_W-1:0]         prm_ram_d;
  logic                      prm_ram_w;
  logic                      busy;
  logic [7:0]                ovr_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  int                addr_tab [N_SLOTS] = '{3, 4, 5, 6};
  logic [DATA_W-1:0] m_shd [N_SLOTS];
  logic [DATA_W-1:0] m_lastw [N_SLOTS];
  bit [N_SLOTS-1:0]  m_pend, m_lv;
  int                m_last, m_phase, m_sel, m_ovr;
  logic [31:0]       m_addr, m_data;
  bit                m_req, m_w, m_busy;

  // Observed write log
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  always #5 clk = ~clk;

  prm_status_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLOTS(N_SLOTS),
    .SLOT_ADDR({8'd6, 8'd5, 8'd4, 8'd3})
  ) dut (
    .clk(clk), .rstn(rstn), .stat_dat(stat_dat), .stat_val(stat_val),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .prm_addr(prm_addr), .prm_ram_d(prm_ram_d),
    .prm_ram_w(prm_ram_w), .busy(busy), .ovr_cnt(ovr_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_SLOTS; i++) begin
      m_shd[i]   = '0;
      m_lastw[i] = '0;
    end
    m_pend = '0; m_lv = '0;
    m_last = N_SLOTS - 1; m_phase = 0; m_sel = 0; m_ovr = 0;
    m_addr = '0; m_data = '0;
    m_req = 0; m_w = 0; m_busy = 0;
  endtask

  // One clock edge of the behavioural model: serve, then capture strobes.
  task automatic modelStep();
    bit [N_SLOTS-1:0] was_pend;
    bit [N_SLOTS-1:0] dropv;
    int sel;
    logic [DATA_W-1:0] d;
    if (!rstn) begin
      modelReset();
      return;
    end
    was_pend = m_pend;
    sel = -1;
    for (int i = 0; i < N_SLOTS; i++) begin
      d = stat_dat[i*DATA_W +: DATA_W];
      dropv[i] = FILTER && m_lv[i] && !was_pend[i] && (d == m_lastw[i]);
    end
    case (m_phase)
      0: if (was_pend != 0) begin
           for (int k = 1; k <= N_SLOTS; k++) begin
             int idx;
             idx = (m_last + k) % N_SLOTS;
             if (sel < 0 && was_pend[idx]) sel = idx;
           end
           m_addr = addr_tab[sel];
           m_data = m_shd[sel];
           m_sel = sel; m_last = sel;
           m_pend[sel] = 1'b0;
           m_req = 1; m_phase = 1;
         end
      1: if (wr_gnt) begin
           m_req = 0; m_w = 1; m_phase = 2;
         end
      default: begin
        if (FILTER) begin
          m_lastw[m_sel] = m_data;
          m_lv[m_sel] = 1'b1;
        end
        m_w = 0; m_phase = 0;
      end
    endcase
    for (int i = 0; i < N_SLOTS; i++) begin
      if (stat_val[i] && !dropv[i]) begin
        if (was_pend[i] && sel != i) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
        m_shd[i] = stat_dat[i*DATA_W +: DATA_W];
        m_pend[i] = 1'b1;
      end
    end
    m_busy = (m_phase != 0) || (m_pend != 0);
  endtask

  task automatic checkAll();
    checkOutput("wr_req",    32'(wr_req),    32'(m_req));
    checkOutput("prm_ram_w", 32'(prm_ram_w), 32'(m_w));
    checkOutput("prm_addr",  32'(prm_addr),  m_addr);
    checkOutput("prm_ram_d", prm_ram_d,      m_data);
    checkOutput("busy",      32'(busy),      32'(m_busy));
    checkOutput("ovr_cnt",   32'(ovr_cnt),   32'(m_ovr));
    if (prm_ram_w === 1'b1) begin
      wq_addr.push_back(int'(prm_addr));
      wq_data.push_back(int'(prm_ram_d));
      wq_cyc.push_back(cyc);
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the next cycle.
  task automatic applyStimulus(input logic [N_SLOTS-1:0] sv, input logic [N_SLOTS*DATA_W-1:0] sd,
                               input logic g);
    stat_val = sv;
    stat_dat = sd;
    wr_gnt   = g;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    checkAll();
  endtask

  task automatic resetDut();
    rstn = 1'b0;
    applyStimulus('0, '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
    rstn = 1'b1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, g);
  endtask

  initial begin
    logic [N_SLOTS-1:0]        sv;
    logic [N_SLOTS*DATA_W-1:0] sd;
    int                        n_wr;
    modelReset();
    @(negedge clk);

    // Reset state
    resetDut();
    checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
    checkOutput("rst_ram_w",  32'(prm_ram_w), 32'd0);
    checkOutput("rst_addr",   32'(prm_addr), 32'd0);
    checkOutput("rst_data",   prm_ram_d, 32'd0);
    checkOutput("rst_busy",   32'(busy), 32'd0);
    checkOutput("rst_ovr",    32'(ovr_cnt), 32'd0);

    // Single write latency
    applyStimulus(4'b0001, {96'd0, 32'h1234}, 1'b1);
    checkOutput("single_req_c1", 32'(wr_req), 32'd0);
    applyStimulus('0, '0, 1'b1);
    checkOutput("single_req_c2", 32'(wr_req), 32'd1);
    applyStimulus('0, '0, 1'b1);
    checkOutput("single_w_c3",    32'(prm_ram_w), 32'd1);
    checkOutput("single_addr_c3", 32'(prm_addr), 32'd3);
    checkOutput("single_data_c3", prm_ram_d, 32'h1234);
    checkOutput("single_ovr",     32'(ovr_cnt), 32'd0);
    idle(3, 1'b1);

    // Round-robin of all four slots
    resetDut();
    applyStimulus(4'b1111, {32'd13, 32'd12, 32'd11, 32'd10}, 1'b1);
    idle(14, 1'b1);
    checkOutput("rr_count", 32'(wq_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      checkOutput("rr_addr", 32'(wq_addr[i]), 32'(3 + i));
      checkOutput("rr_data", 32'(wq_data[i]), 32'(10 + i));
      if (i > 0) checkOutput("rr_spacing", 32'(wq_cyc[i] - wq_cyc[i-1]), 32'd3);
    end
    checkOutput("rr_busy_after", 32'(busy), 32'd0);

    // Stalled grant and overrun on slot 1
    resetDut();
    applyStimulus(4'b0010, {64'd0, 32'd5, 32'd0}, 1'b0);
    applyStimulus(4'b0010, {64'd0, 32'd6, 32'd0}, 1'b0);
    applyStimulus(4'b0010, {64'd0, 32'd7, 32'd0}, 1'b0);
    idle(4, 1'b0);
    checkOutput("stall_req",  32'(wr_req), 32'd1);
    checkOutput("stall_data", prm_ram_d, 32'd5);
    checkOutput("stall_addr", 32'(prm_addr), 32'd4);
    checkOutput("stall_ovr",  32'(ovr_cnt), 32'd1);
    idle(10, 1'b1);
    checkOutput("stall_count", 32'(wq_addr.size()), 32'd2);
    for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
      checkOutput("stall_wr_addr", 32'(wq_addr[i]), 32'd4);
      checkOutput("stall_wr_data", 32'(wq_data[i]), (i == 0) ? 32'd5 : 32'd7);
    end
    checkOutput("stall_ovr_end", 32'(ovr_cnt), 32'd1);

    // Asynchronous reset while prm_ram_w is high
    resetDut();
    applyStimulus(4'b1000, {32'hDEAD, 96'd0}, 1'b1);
    applyStimulus(4'b0001, {96'd0, 32'h77}, 1'b1);
    applyStimulus('0, '0, 1'b1);
    checkOutput("midrst_pre_w", 32'(prm_ram_w), 32'd1);
    #1 rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_w",    32'(prm_ram_w), 32'd0);
    checkOutput("midrst_req",  32'(wr_req), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_addr", 32'(prm_addr), 32'd0);
    @(negedge clk);
    applyStimulus('0, '0, 1'b1);
    rstn = 1'b1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    idle(10, 1'b1);
    checkOutput("midrst_no_writes", 32'(wq_addr.size()), 32'd0);

    // Repeated value filter on slot 2
    resetDut();
    applyStimulus(4'b0100, {32'd0, 32'hAA, 64'd0}, 1'b1);
    idle(9, 1'b1);
    applyStimulus(4'b0100, {32'd0, 32'hAA, 64'd0}, 1'b1);
    idle(9, 1'b1);
    applyStimulus(4'b0100, {32'd0, 32'hAB, 64'd0}, 1'b1);
    idle(9, 1'b1);
    n_wr = FILTER ? 2 : 3;
    checkOutput("filter_count", 32'(wq_addr.size()), 32'(n_wr));
    if (wq_data.size() > 0)
      checkOutput("filter_last_data", 32'(wq_data[wq_data.size()-1]), 32'hAB);

    // Overrun counter saturation
    resetDut();
    for (int n = 0; n < 70; n++) applyStimulus(4'b1111, {4{32'(n)}}, 1'b0);
    checkOutput("ovr_saturated", 32'(ovr_cnt), 32'd255);

    // Randomized traffic with a random grant
    resetDut();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        sv[i] = ($urandom_range(0, 3) == 0);
        sd[i*DATA_W +: DATA_W] = $urandom_range(0, 3);
      end
      applyStimulus(sv, sd, $urandom_range(0, 9) < 7);
    end
    idle(20, 1'b1);
    checkOutput("rand_drained_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
